// File: rtl/dev_arb_pkg.sv
// Shared types for the two-cluster device port arbiter: FSM states, operation
// codes and the holding-register entry layout.
package dev_arb_pkg;

    localparam int NUM_REQ           = 2;
    localparam int DEV_ADDR_WIDTH    = 10;
    localparam int DEV_DATA_WIDTH    = 16;
    localparam int DEV_CORE_ID_WIDTH = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef enum logic {OP_READ, OP_WRITE} op_t;

    // Field widths are fixed here; the top-level width parameters must match them.
    typedef struct packed {
        op_t                          op;
        logic [DEV_ADDR_WIDTH-1:0]    addr;
        logic [DEV_DATA_WIDTH-1:0]    data;
        logic [DEV_CORE_ID_WIDTH-1:0] core_id;
    } dev_req_t;

endpackage

// File: rtl/dev_req_slot.sv
// One-deep holding register for a single requester. A request is taken only
// while the slot is empty; the arbiter empties it when the transaction ends.
module dev_req_slot
    import dev_arb_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_en,
    input  logic                         read_en,
    input  logic [DEV_ADDR_WIDTH-1:0]    addr,
    input  logic [DEV_DATA_WIDTH-1:0]    data,
    input  logic [DEV_CORE_ID_WIDTH-1:0] core_id,
    input  logic                         clear,
    output logic                         pending,
    output dev_req_t                     entry
);

    logic     pending_reg;
    dev_req_t entry_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= 1'b0;
            entry_reg   <= '0;
        end else if (clear) begin
            // Clear only happens while full, so a request at this edge is dropped.
            pending_reg <= 1'b0;
        end else if ((write_en || read_en) && !pending_reg) begin
            pending_reg       <= 1'b1;
            entry_reg.op      <= write_en ? OP_WRITE : OP_READ;
            entry_reg.addr    <= addr;
            entry_reg.data    <= data;
            entry_reg.core_id <= core_id;
        end
    end

    assign pending = pending_reg;
    assign entry   = entry_reg;

endmodule

// File: rtl/dev_port_arbiter.sv
// Round-robin arbiter sharing one req/ack device port between two cluster
// requesters, with an optional timeout abort for unacknowledged transactions.
module dev_port_arbiter
    import dev_arb_pkg::*;
#(
    parameter int NUM_CORES      = 16,
    parameter int CORE_ID_WIDTH  = $clog2(NUM_CORES),
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_write_en,
    input  logic [NUM_REQ-1:0]                 req_read_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ*CORE_ID_WIDTH-1:0]   req_core_id,
    output logic [NUM_REQ-1:0]                 req_busy,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic                               rsp_err,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic [CORE_ID_WIDTH-1:0]           rsp_core_id,
    output logic                               dev_write_en,
    output logic                               dev_read_en,
    output logic [ADDR_WIDTH-1:0]              dev_addr,
    output logic [DATA_WIDTH-1:0]              dev_data_out,
    output logic [CORE_ID_WIDTH-1:0]           dev_core_id,
    input  logic                               dev_ack,
    input  logic [DATA_WIDTH-1:0]              dev_data_in
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] clear;
    dev_req_t           entry [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            dev_req_slot u_slot (
                .clk      (clk),
                .reset    (reset),
                .write_en (req_write_en[gi]),
                .read_en  (req_read_en[gi]),
                .addr     (req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                .data     (req_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .core_id  (req_core_id[gi*CORE_ID_WIDTH +: CORE_ID_WIDTH]),
                .clear    (clear[gi]),
                .pending  (pending[gi]),
                .entry    (entry[gi])
            );
        end
    endgenerate

    state_t                   state_reg, state_next;
    logic                     rr_reg, rr_next;
    logic                     winner_reg, winner_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [NUM_REQ-1:0]       rsp_valid_reg, rsp_valid_next;
    logic                     rsp_err_reg, rsp_err_next;
    logic [DATA_WIDTH-1:0]    rsp_data_reg, rsp_data_next;
    logic [CORE_ID_WIDTH-1:0] rsp_core_id_reg, rsp_core_id_next;
    logic                     dev_write_en_reg, dev_write_en_next;
    logic                     dev_read_en_reg, dev_read_en_next;
    logic [ADDR_WIDTH-1:0]    dev_addr_reg, dev_addr_next;
    logic [DATA_WIDTH-1:0]    dev_data_reg, dev_data_next;
    logic [CORE_ID_WIDTH-1:0] dev_core_id_reg, dev_core_id_next;
    logic                     gnt;
    logic                     timed_out;

    // cnt_reg holds (BUSY edges seen - 1), so the match marks the final allowed edge.
    assign timed_out = (TIMEOUT_CYCLES > 0) && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next        = state_reg;
        rr_next           = rr_reg;
        winner_next       = winner_reg;
        cnt_next          = cnt_reg;
        rsp_valid_next    = '0;
        rsp_err_next      = rsp_err_reg;
        rsp_data_next     = rsp_data_reg;
        rsp_core_id_next  = rsp_core_id_reg;
        dev_write_en_next = dev_write_en_reg;
        dev_read_en_next  = dev_read_en_reg;
        dev_addr_next     = dev_addr_reg;
        dev_data_next     = dev_data_reg;
        dev_core_id_next  = dev_core_id_reg;
        clear             = '0;
        gnt               = pending[rr_reg] ? rr_reg : ~rr_reg;

        case (state_reg)
            IDLE: begin
                if (|pending) begin
                    winner_next       = gnt;
                    dev_write_en_next = (entry[gnt].op == OP_WRITE);
                    dev_read_en_next  = (entry[gnt].op == OP_READ);
                    dev_addr_next     = entry[gnt].addr;
                    dev_data_next     = entry[gnt].data;
                    dev_core_id_next  = entry[gnt].core_id;
                    cnt_next          = '0;
                    state_next        = BUSY;
                end
            end
            BUSY: begin
                if (dev_ack || timed_out) begin
                    // An ack at the timeout edge still counts as a normal completion.
                    dev_write_en_next           = 1'b0;
                    dev_read_en_next            = 1'b0;
                    rsp_valid_next[winner_reg]  = 1'b1;
                    rsp_err_next                = !dev_ack;
                    rsp_data_next               = (dev_ack && dev_read_en_reg) ? dev_data_in : '0;
                    rsp_core_id_next            = dev_core_id_reg;
                    clear[winner_reg]           = 1'b1;
                    rr_next                     = ~winner_reg;
                    state_next                  = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            rr_reg           <= 1'b0;
            winner_reg       <= 1'b0;
            cnt_reg          <= '0;
            rsp_valid_reg    <= '0;
            rsp_err_reg      <= 1'b0;
            rsp_data_reg     <= '0;
            rsp_core_id_reg  <= '0;
            dev_write_en_reg <= 1'b0;
            dev_read_en_reg  <= 1'b0;
            dev_addr_reg     <= '0;
            dev_data_reg     <= '0;
            dev_core_id_reg  <= '0;
        end else begin
            state_reg        <= state_next;
            rr_reg           <= rr_next;
            winner_reg       <= winner_next;
            cnt_reg          <= cnt_next;
            rsp_valid_reg    <= rsp_valid_next;
            rsp_err_reg      <= rsp_err_next;
            rsp_data_reg     <= rsp_data_next;
            rsp_core_id_reg  <= rsp_core_id_next;
            dev_write_en_reg <= dev_write_en_next;
            dev_read_en_reg  <= dev_read_en_next;
            dev_addr_reg     <= dev_addr_next;
            dev_data_reg     <= dev_data_next;
            dev_core_id_reg  <= dev_core_id_next;
        end
    end

    assign req_busy     = pending;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_err      = rsp_err_reg;
    assign rsp_data     = rsp_data_reg;
    assign rsp_core_id  = rsp_core_id_reg;
    assign dev_write_en = dev_write_en_reg;
    assign dev_read_en  = dev_read_en_reg;
    assign dev_addr     = dev_addr_reg;
    assign dev_data_out = dev_data_reg;
    assign dev_core_id  = dev_core_id_reg;

endmodule

// File: doc/dev_port_arbiter.md
Name: dev_port_arbiter

Overview:
- Shares one external device port between the device request ports of the two memory clusters (requester 0 = cluster 1, requester 1 = cluster 2).
- Each requester has a one-deep holding register.
- A round-robin FSM issues one transaction at a time to the device using a req/ack handshake.
- Returns read data or write completion to the originating requester. A timeout aborts transactions the device never acknowledges.

Parameters:
- NUM_CORES, 16: cores per cluster; sets core-id width.
- CORE_ID_WIDTH, $clog2(NUM_CORES): width of core-id fields.
- ADDR_WIDTH, 10: device address width.
- DATA_WIDTH, 16: device data width.
- TIMEOUT_CYCLES, 64: maximum cycles waiting for dev_ack; 0 disables the timeout.

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- req_write_en  in  2  per-requester write request (bit i = requester i)
- req_read_en  in  2  per-requester read request
- req_addr  in  2xADDR_WIDTH  per-requester address
- req_data  in  2xDATA_WIDTH  per-requester write data
- req_core_id  in  2xCORE_ID_WIDTH  per-requester issuing core id
- req_busy  out  2  holding register full; requester must hold off
- rsp_valid  out  2  one-cycle completion pulse per requester
- rsp_err  out  1  completion was a timeout abort (qualified by rsp_valid)
- rsp_data  out  DATA_WIDTH  read data (qualified by rsp_valid)
- rsp_core_id  out  CORE_ID_WIDTH  core id of the completed transaction
- dev_write_en  out  1  device write strobe, held until ack
- dev_read_en  out  1  device read strobe, held until ack
- dev_addr  out  ADDR_WIDTH  device address
- dev_data_out  out  DATA_WIDTH  device write data
- dev_core_id  out  CORE_ID_WIDTH  core id of the granted requester
- dev_ack  in  1  device completion, sampled while a strobe is high
- dev_data_in  in  DATA_WIDTH  device read data, valid with dev_ack

Behaviour:
- Reset value of every output, all holding registers and the timeout counter is 0. FSM resets to IDLE with round-robin priority on requester 0.
- Reset mid-transaction drops all pending and in-flight requests; no rsp_valid is generated.
- Capture: at an edge where (req_write_en[i] | req_read_en[i]) and pending[i]=0, latch op, addr, data and core_id; pending[i] becomes 1. req_busy[i] = pending[i] (registered).
- Requests presented while pending[i]=1 are ignored, including at the edge where pending clears.
- Write and read asserted together: write wins, read is discarded.
- FSM IDLE: if any pending, grant the highest-priority pending requester and register the dev_* outputs from its holding register; go to BUSY. With no pending requests, stay in IDLE with dev_* strobes low.
- FSM BUSY: hold dev_* outputs stable; the timeout counter increments each cycle.
  - At the edge dev_ack=1: strobes drop and rsp_valid[winner] pulses for exactly 1 cycle. rsp_data = dev_data_in for a read, 0 for a write; rsp_err = 0.
  - At the same edge: pending[winner] clears, priority moves to the other requester, FSM returns to IDLE.
- Timeout: if TIMEOUT_CYCLES>0 and no ack by the TIMEOUT_CYCLES-th BUSY cycle, abort at that edge. Same as completion but rsp_err = 1 and rsp_data = 0.
- dev_ack and timeout at the same edge: the ack wins (normal completion).
- dev_ack in IDLE is ignored.
- Latency: request sampled at edge t → strobe high after edge t+1 (when IDLE) → ack at edge u → rsp_valid in the cycle after u.
- Minimum one IDLE cycle between device transactions.
- Round-robin: with both pending, grants strictly alternate. A lone requester is granted regardless of priority.
- Counter width: $clog2(TIMEOUT_CYCLES+1), cleared on grant; no wrap because the abort occurs first.

Decomposition:
- Package dev_arb_pkg holds:
  - state enum {IDLE, BUSY};
  - op enum {OP_READ, OP_WRITE};
  - packed struct dev_req_t {op, addr, data, core_id};
  - NUM_REQ = 2.
- One sub-module, dev_req_slot: the per-requester holding register with capture/clear/busy logic, instantiated twice.
- The FSM, round-robin pointer and timeout counter stay in the top.

Test Plan:
- Req 0 read addr 0x155 core 3; dev_ack 2 cycles after strobe with dev_data_in=0xBEEF → dev_read_en/addr 0x155/core 3 held until ack; rsp_valid=2'b01, rsp_data=0xBEEF, rsp_err=0, req_busy[0] low the next cycle.
- Both requesters write in the same cycle (addr 0x010 and 0x020), 4 transactions each, immediate acks → device sees 0x010, 0x020, 0x010, ... strictly alternating; 8 completions with no loss.
- Write and read asserted together on req 1 → only dev_write_en asserted; the read never appears.
- TIMEOUT_CYCLES=8, no dev_ack → after 8 BUSY cycles rsp_valid for the granted requester with rsp_err=1, rsp_data=0; the next pending requester is served.
- dev_ack arriving on exactly the 8th BUSY cycle → normal completion, rsp_err=0.
- Reset asserted while BUSY with both requesters pending → all outputs 0 the next cycle, no rsp_valid; the first post-reset request is granted to requester 0 when both request.
